// File: rtl/dram_mem_arbiter_if.sv
// DRAM-controller side of the memory arbiter: one command channel plus the
// unstallable in-order read-return strobe.
interface dram_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 144,
    parameter int BE_WIDTH   = 18
);
    logic                  dram_reset;
    logic [ADDR_WIDTH-1:0] dram_address;
    logic                  dram_rnw;
    logic                  dram_cmd_en;
    logic                  dram_ready;
    logic [DATA_WIDTH-1:0] dram_data_o;
    logic [BE_WIDTH-1:0]   dram_byte_enable;
    logic [DATA_WIDTH-1:0] dram_data_i;
    logic                  dram_data_valid;

    modport master (
        output dram_reset, dram_address, dram_rnw, dram_cmd_en,
               dram_data_o, dram_byte_enable,
        input  dram_ready, dram_data_i, dram_data_valid
    );

    modport slave (
        input  dram_reset, dram_address, dram_rnw, dram_cmd_en,
               dram_data_o, dram_byte_enable,
        output dram_ready, dram_data_i, dram_data_valid
    );
endinterface

// File: rtl/dram_mem_arbiter.sv
// Round-robin arbiter merging NUM_PORTS memory masters onto one DRAM command
// port, with credit-limited reads returned in DRAM order to the issuing port.
module dram_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 144,
    parameter int BE_WIDTH   = 18,
    parameter int TAG_WIDTH  = 32,
    parameter int RD_DEPTH   = 16
) (
    input  logic                            Mem_Clk,
    input  logic                            Mem_Rst,
    dram_mem_arbiter_if.master              dram,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] Mem_Cmd_Address,
    input  logic [NUM_PORTS-1:0]            Mem_Cmd_RNW,
    input  logic [NUM_PORTS-1:0]            Mem_Cmd_Valid,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0]  Mem_Cmd_Tag,
    output logic [NUM_PORTS-1:0]            Mem_Cmd_Ack,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] Mem_Wr_Din,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   Mem_Wr_BE,
    output logic [DATA_WIDTH-1:0]           Mem_Rd_Dout,
    output logic [TAG_WIDTH-1:0]            Mem_Rd_Tag,
    output logic [NUM_PORTS-1:0]            Mem_Rd_Valid,
    input  logic [NUM_PORTS-1:0]            Mem_Rd_Ack,
    output logic                            arb_error
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int FW = $clog2(RD_DEPTH);
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef struct packed {
        logic [PW-1:0]        port;
        logic [TAG_WIDTH-1:0] tag;
    } tag_entry_t;

    typedef struct packed {
        logic [PW-1:0]         port;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } ret_entry_t;

    logic                  cmd_en, cmd_rnw, dram_reset_q;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [BE_WIDTH-1:0]   cmd_be;

    logic                  accept, cmd_free, credit;
    logic [NUM_PORTS-1:0]  eligible;
    logic [PW-1:0]         rr_start, grant_idx, cand_idx;
    logic [PW:0]           cand_sum;
    logic                  grant_any, grant_read;
    logic [CW-1:0]         outstanding;

    tag_entry_t            tag_mem [RD_DEPTH];
    tag_entry_t            tag_in;
    logic [FW-1:0]         tag_wr, tag_rd;
    logic [CW-1:0]         tag_count;
    logic                  tag_empty, tag_pop;

    ret_entry_t            ret_mem [RD_DEPTH];
    ret_entry_t            ret_in, ret_head;
    logic [FW-1:0]         ret_wr, ret_rd;
    logic [CW-1:0]         ret_count;
    logic                  ret_empty, ret_full, ret_push, ret_pop;

    assign accept     = cmd_en && dram.dram_ready;
    assign cmd_free   = !cmd_en || accept;
    assign credit     = outstanding < CW'(RD_DEPTH);
    assign grant_read = grant_any && Mem_Cmd_RNW[grant_idx];

    assign tag_empty  = (tag_count == '0);
    assign ret_empty  = (ret_count == '0);
    assign ret_full   = (ret_count == CW'(RD_DEPTH));
    assign tag_pop    = dram.dram_data_valid && !tag_empty;
    assign ret_push   = tag_pop && !ret_full;
    assign ret_head   = ret_mem[ret_rd];
    assign ret_pop    = !ret_empty && Mem_Rd_Ack[ret_head.port];

    assign tag_in = '{port: grant_idx, tag: Mem_Cmd_Tag[grant_idx*TAG_WIDTH +: TAG_WIDTH]};
    assign ret_in = '{port: tag_mem[tag_rd].port, tag: tag_mem[tag_rd].tag,
                      data: dram.dram_data_i};

    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            eligible[p] = Mem_Cmd_Valid[p] && (!Mem_Cmd_RNW[p] || credit);
    end

    // Rotating search starting one past the last granted port.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_sum = {1'b0, rr_start} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(NUM_PORTS))
                cand_sum = cand_sum - (PW+1)'(NUM_PORTS);
            cand_idx = cand_sum[PW-1:0];
            if (!Mem_Rst && !grant_any && cmd_free && eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        Mem_Cmd_Ack = '0;
        if (grant_any)
            Mem_Cmd_Ack[grant_idx] = 1'b1;
    end

    always_comb begin
        Mem_Rd_Valid = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (!ret_empty && ret_head.port == PW'(p))
                Mem_Rd_Valid[p] = 1'b1;
    end

    assign Mem_Rd_Dout = ret_head.data;
    assign Mem_Rd_Tag  = ret_head.tag;

    assign dram.dram_reset       = dram_reset_q;
    assign dram.dram_cmd_en      = cmd_en;
    assign dram.dram_rnw         = cmd_rnw;
    assign dram.dram_address     = cmd_addr;
    assign dram.dram_data_o      = cmd_data;
    assign dram.dram_byte_enable = cmd_be;

    always_ff @(posedge Mem_Clk) begin
        dram_reset_q <= Mem_Rst;
        if (Mem_Rst) begin
            cmd_en      <= 1'b0;
            cmd_rnw     <= 1'b1;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            cmd_be      <= '0;
            rr_start    <= '0;
            outstanding <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            tag_count   <= '0;
            ret_wr      <= '0;
            ret_rd      <= '0;
            ret_count   <= '0;
            arb_error   <= 1'b0;
        end else begin
            if (grant_any) begin
                cmd_en   <= 1'b1;
                cmd_rnw  <= Mem_Cmd_RNW[grant_idx];
                cmd_addr <= Mem_Cmd_Address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_data <= Mem_Wr_Din[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                cmd_be   <= Mem_Wr_BE[grant_idx*BE_WIDTH +: BE_WIDTH];
                rr_start <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end else if (accept) begin
                cmd_en <= 1'b0;
            end

            if (grant_read) tag_wr <= tag_wr + 1'b1;
            if (tag_pop)    tag_rd <= tag_rd + 1'b1;
            tag_count <= tag_count + CW'(grant_read) - CW'(tag_pop);

            if (ret_push) ret_wr <= ret_wr + 1'b1;
            if (ret_pop)  ret_rd <= ret_rd + 1'b1;
            ret_count <= ret_count + CW'(ret_push) - CW'(ret_pop);

            // Credit is returned only when the port consumes the data.
            outstanding <= outstanding + CW'(grant_read) - CW'(ret_pop);

            if (dram.dram_data_valid && (tag_empty || ret_full))
                arb_error <= 1'b1;
        end
    end

    always_ff @(posedge Mem_Clk) begin
        if (grant_read) tag_mem[tag_wr] <= tag_in;
        if (ret_push)   ret_mem[ret_wr] <= ret_in;
    end
endmodule

// File: tb/tb_dram_mem_arbiter.sv
// Self-checking bench for dram_mem_arbiter: directed table and sequences,
// then random traffic against a queue-based reference model.
module tb_dram_mem_arbiter;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 144;
    localparam int BW = 18;
    localparam int TW = 32;
    localparam int RD = 4;

    logic              Mem_Clk = 1'b0;
    logic              Mem_Rst;
    logic [NP*AW-1:0]  Mem_Cmd_Address;
    logic [NP-1:0]     Mem_Cmd_RNW, Mem_Cmd_Valid, Mem_Cmd_Ack;
    logic [NP*TW-1:0]  Mem_Cmd_Tag;
    logic [NP*DW-1:0]  Mem_Wr_Din;
    logic [NP*BW-1:0]  Mem_Wr_BE;
    logic [DW-1:0]     Mem_Rd_Dout;
    logic [TW-1:0]     Mem_Rd_Tag;
    logic [NP-1:0]     Mem_Rd_Valid, Mem_Rd_Ack;
    logic              arb_error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] rnw;
        logic [NP-1:0] exp_ack;
    } rr_vec_t;
    rr_vec_t rr_tab [14];

    typedef struct { int port; logic [TW-1:0] tag; } tag_t;
    typedef struct { int port; logic [TW-1:0] tag; logic [DW-1:0] data; } ret_t;
    tag_t tagq [$];
    ret_t retq [$];
    tag_t tq_head;

    bit            m_en, m_rnw, m_err, m_pop, m_free, m_credit;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, a_data, d1, d2;
    logic [BW-1:0] m_be;
    int            m_next, m_g, ack_count;
    logic [NP-1:0] exp_ack, exp_rdv, prev_ack, prev_rnw;

    dram_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    dram_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BE_WIDTH(BW), .TAG_WIDTH(TW), .RD_DEPTH(RD)
    ) dut (
        .Mem_Clk         (Mem_Clk),
        .Mem_Rst         (Mem_Rst),
        .dram            (bus),
        .Mem_Cmd_Address (Mem_Cmd_Address),
        .Mem_Cmd_RNW     (Mem_Cmd_RNW),
        .Mem_Cmd_Valid   (Mem_Cmd_Valid),
        .Mem_Cmd_Tag     (Mem_Cmd_Tag),
        .Mem_Cmd_Ack     (Mem_Cmd_Ack),
        .Mem_Wr_Din      (Mem_Wr_Din),
        .Mem_Wr_BE       (Mem_Wr_BE),
        .Mem_Rd_Dout     (Mem_Rd_Dout),
        .Mem_Rd_Tag      (Mem_Rd_Tag),
        .Mem_Rd_Valid    (Mem_Rd_Valid),
        .Mem_Rd_Ack      (Mem_Rd_Ack),
        .arb_error       (arb_error)
    );

    always #5 Mem_Clk = ~Mem_Clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Mem_Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input int p, input logic valid, input logic rnw,
                                 input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                                 input logic [DW-1:0] data, input logic [BW-1:0] be);
        Mem_Cmd_Valid[p]          = valid;
        Mem_Cmd_RNW[p]            = rnw;
        Mem_Cmd_Address[p*AW +: AW] = addr;
        Mem_Cmd_Tag[p*TW +: TW]     = tag;
        Mem_Wr_Din[p*DW +: DW]      = data;
        Mem_Wr_BE[p*BW +: BW]       = be;
    endtask

    task automatic clearInputs();
        Mem_Cmd_Address     = '0;
        Mem_Cmd_RNW         = '0;
        Mem_Cmd_Valid       = '0;
        Mem_Cmd_Tag         = '0;
        Mem_Wr_Din          = '0;
        Mem_Wr_BE           = '0;
        Mem_Rd_Ack          = '0;
        bus.dram_ready      = 1'b1;
        bus.dram_data_valid = 1'b0;
        bus.dram_data_i     = '0;
    endtask

    task automatic doReset();
        Mem_Rst = 1'b1;
        clearInputs();
        tick();
        tick();
        Mem_Rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    function automatic logic [AW-1:0] port_addr(input int p);
        return AW'(32'h1000 + p * 16);
    endfunction

    function automatic logic [DW-1:0] port_data(input int p);
        return (DW'(p + 1) << 100) | DW'(32'hCAFE0000 + p);
    endfunction

    function automatic int onehot_idx(input logic [NP-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NP; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

    initial begin
        // Round-robin vectors from reset (pointer at port 0), dram_ready held high.
        rr_tab[0]  = '{4'b0011, 4'b0000, 4'b0001};
        rr_tab[1]  = '{4'b0011, 4'b0000, 4'b0010};
        rr_tab[2]  = '{4'b0011, 4'b0001, 4'b0001};
        rr_tab[3]  = '{4'b0011, 4'b0000, 4'b0010};
        rr_tab[4]  = '{4'b1111, 4'b0000, 4'b0100};
        rr_tab[5]  = '{4'b1111, 4'b1000, 4'b1000};
        rr_tab[6]  = '{4'b1111, 4'b0000, 4'b0001};
        rr_tab[7]  = '{4'b1111, 4'b0000, 4'b0010};
        rr_tab[8]  = '{4'b1111, 4'b0000, 4'b0100};
        rr_tab[9]  = '{4'b1000, 4'b0000, 4'b1000};
        rr_tab[10] = '{4'b0000, 4'b0000, 4'b0000};
        rr_tab[11] = '{4'b0100, 4'b0000, 4'b0100};
        rr_tab[12] = '{4'b0001, 4'b0000, 4'b0001};
        rr_tab[13] = '{4'b0110, 4'b0000, 4'b0010};

        doReset();
        settle();
        checkOutput("rst_cmd_en",  160'(bus.dram_cmd_en), 160'(0));
        checkOutput("rst_rnw",     160'(bus.dram_rnw), 160'(1));
        checkOutput("rst_addr",    160'(bus.dram_address), 160'(0));
        checkOutput("rst_data",    160'(bus.dram_data_o), 160'(0));
        checkOutput("rst_be",      160'(bus.dram_byte_enable), 160'(0));
        checkOutput("rst_ack",     160'(Mem_Cmd_Ack), 160'(0));
        checkOutput("rst_rdvalid", 160'(Mem_Rd_Valid), 160'(0));
        checkOutput("rst_error",   160'(arb_error), 160'(0));
        checkOutput("rst_dram_reset", 160'(bus.dram_reset), 160'(1));
        tick();
        settle();
        checkOutput("dram_reset_release", 160'(bus.dram_reset), 160'(0));

        // Single port write
        a_data = rand_data();
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, a_data, 18'h3FFFF);
        settle();
        checkOutput("wr_ack", 160'(Mem_Cmd_Ack), 160'(4'b0001));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, '0, '0);
        settle();
        checkOutput("wr_cmd_en", 160'(bus.dram_cmd_en), 160'(1));
        checkOutput("wr_rnw",    160'(bus.dram_rnw), 160'(0));
        checkOutput("wr_addr",   160'(bus.dram_address), 160'(32'h100));
        checkOutput("wr_data",   160'(bus.dram_data_o), 160'(a_data));
        checkOutput("wr_be",     160'(bus.dram_byte_enable), 160'(18'h3FFFF));
        checkOutput("wr_ack_once", 160'(Mem_Cmd_Ack), 160'(0));

        // Table-driven round robin
        doReset();
        prev_ack = '0;
        prev_rnw = '0;
        for (int i = 0; i < 14; i++) begin
            for (int p = 0; p < NP; p++)
                applyStimulus(p, rr_tab[i].valid[p], rr_tab[i].rnw[p], port_addr(p),
                              TW'(p), port_data(p), BW'(p + 1));
            settle();
            checkOutput("rr_ack", 160'(Mem_Cmd_Ack), 160'(rr_tab[i].exp_ack));
            checkOutput("rr_cmd_en", 160'(bus.dram_cmd_en), 160'(prev_ack != '0));
            if (prev_ack != '0) begin
                checkOutput("rr_addr", 160'(bus.dram_address), 160'(port_addr(onehot_idx(prev_ack))));
                checkOutput("rr_data", 160'(bus.dram_data_o), 160'(port_data(onehot_idx(prev_ack))));
                checkOutput("rr_rnw", 160'(bus.dram_rnw), 160'(prev_rnw[onehot_idx(prev_ack)]));
            end
            prev_ack = rr_tab[i].exp_ack;
            prev_rnw = rr_tab[i].rnw;
            tick();
        end

        // Backpressure: command held stable while dram_ready is low
        doReset();
        bus.dram_ready = 1'b0;
        applyStimulus(2, 1'b1, 1'b0, 32'h2000, 32'h0, port_data(2), 18'h00F0F);
        settle();
        checkOutput("bp_first_ack", 160'(Mem_Cmd_Ack), 160'(4'b0100));
        tick();
        applyStimulus(2, 1'b1, 1'b0, 32'h3000, 32'h0, port_data(3), 18'h30303);
        for (int i = 0; i < 5; i++) begin
            settle();
            checkOutput("bp_cmd_en", 160'(bus.dram_cmd_en), 160'(1));
            checkOutput("bp_addr",   160'(bus.dram_address), 160'(32'h2000));
            checkOutput("bp_data",   160'(bus.dram_data_o), 160'(port_data(2)));
            checkOutput("bp_be",     160'(bus.dram_byte_enable), 160'(18'h00F0F));
            checkOutput("bp_no_ack", 160'(Mem_Cmd_Ack), 160'(0));
            tick();
        end
        bus.dram_ready = 1'b1;
        settle();
        checkOutput("bp_release_ack", 160'(Mem_Cmd_Ack), 160'(4'b0100));
        checkOutput("bp_release_addr", 160'(bus.dram_address), 160'(32'h2000));
        tick();
        applyStimulus(2, 1'b0, 1'b0, 32'h0, 32'h0, '0, '0);
        settle();
        checkOutput("bp_next_addr", 160'(bus.dram_address), 160'(32'h3000));
        checkOutput("bp_next_be",   160'(bus.dram_byte_enable), 160'(18'h30303));
        checkOutput("bp_next_en",   160'(bus.dram_cmd_en), 160'(1));
        tick();
        settle();
        checkOutput("bp_idle_en", 160'(bus.dram_cmd_en), 160'(0));

        // Read routing with tag preservation and head-of-line ordering
        doReset();
        d1 = rand_data();
        d2 = rand_data();
        applyStimulus(1, 1'b1, 1'b1, 32'h4100, 32'hA, '0, '0);
        settle();
        checkOutput("rd_ack_p1", 160'(Mem_Cmd_Ack), 160'(4'b0010));
        tick();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, '0, '0);
        applyStimulus(0, 1'b1, 1'b1, 32'h4000, 32'hB, '0, '0);
        settle();
        checkOutput("rd_ack_p0", 160'(Mem_Cmd_Ack), 160'(4'b0001));
        checkOutput("rd_cmd_rnw", 160'(bus.dram_rnw), 160'(1));
        checkOutput("rd_cmd_addr", 160'(bus.dram_address), 160'(32'h4100));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, '0, '0);
        bus.dram_data_valid = 1'b1;
        bus.dram_data_i     = d1;
        settle();
        checkOutput("rd_latency", 160'(Mem_Rd_Valid), 160'(0));
        tick();
        bus.dram_data_i = d2;
        Mem_Rd_Ack      = 4'b0001;
        settle();
        checkOutput("rd1_valid", 160'(Mem_Rd_Valid), 160'(4'b0010));
        checkOutput("rd1_tag",   160'(Mem_Rd_Tag), 160'(32'hA));
        checkOutput("rd1_data",  160'(Mem_Rd_Dout), 160'(d1));
        tick();
        bus.dram_data_valid = 1'b0;
        Mem_Rd_Ack          = 4'b0010;
        settle();
        checkOutput("rd_nonhead_ignored", 160'(Mem_Rd_Valid), 160'(4'b0010));
        checkOutput("rd_nonhead_tag", 160'(Mem_Rd_Tag), 160'(32'hA));
        tick();
        Mem_Rd_Ack = 4'b0001;
        settle();
        checkOutput("rd2_valid", 160'(Mem_Rd_Valid), 160'(4'b0001));
        checkOutput("rd2_tag",   160'(Mem_Rd_Tag), 160'(32'hB));
        checkOutput("rd2_data",  160'(Mem_Rd_Dout), 160'(d2));
        tick();
        Mem_Rd_Ack = '0;
        settle();
        checkOutput("rd_drained", 160'(Mem_Rd_Valid), 160'(0));

        // Credit limit of RD outstanding reads
        doReset();
        ack_count = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 1'b1, 1'b1, 32'h5000, TW'(c), '0, '0);
            applyStimulus(1, (c == 6), 1'b0, 32'h5100, 32'h0, port_data(1), 18'h1);
            settle();
            if (Mem_Cmd_Ack[0]) ack_count++;
            if (c == 6) checkOutput("cr_write_passes", 160'(Mem_Cmd_Ack), 160'(4'b0010));
            tick();
        end
        checkOutput("cr_read_acks", 160'(ack_count), 160'(RD));
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, '0, '0);
        bus.dram_data_valid = 1'b1;
        bus.dram_data_i     = d1;
        settle();
        checkOutput("cr_no_credit", 160'(Mem_Cmd_Ack), 160'(0));
        tick();
        bus.dram_data_valid = 1'b0;
        Mem_Rd_Ack          = 4'b0001;
        settle();
        checkOutput("cr_ret_valid", 160'(Mem_Rd_Valid), 160'(4'b0001));
        checkOutput("cr_ret_tag", 160'(Mem_Rd_Tag), 160'(0));
        checkOutput("cr_pop_cycle_no_ack", 160'(Mem_Cmd_Ack), 160'(0));
        tick();
        Mem_Rd_Ack = '0;
        settle();
        checkOutput("cr_fifth_read_ack", 160'(Mem_Cmd_Ack), 160'(4'b0001));
        tick();
        settle();
        checkOutput("cr_sixth_blocked", 160'(Mem_Cmd_Ack), 160'(0));

        // Protocol error and mid-burst reset
        doReset();
        bus.dram_data_valid = 1'b1;
        settle();
        checkOutput("err_before", 160'(arb_error), 160'(0));
        tick();
        bus.dram_data_valid = 1'b0;
        settle();
        checkOutput("err_set", 160'(arb_error), 160'(1));
        tick();
        bus.dram_ready = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h6000, 32'h0, port_data(0), 18'h3);
        applyStimulus(1, 1'b1, 1'b1, 32'h6100, 32'h7, '0, '0);
        settle();
        checkOutput("err_sticky", 160'(arb_error), 160'(1));
        tick();
        tick();
        Mem_Rst = 1'b1;
        clearInputs();
        tick();
        settle();
        checkOutput("mr_cmd_en",  160'(bus.dram_cmd_en), 160'(0));
        checkOutput("mr_rnw",     160'(bus.dram_rnw), 160'(1));
        checkOutput("mr_addr",    160'(bus.dram_address), 160'(0));
        checkOutput("mr_data",    160'(bus.dram_data_o), 160'(0));
        checkOutput("mr_be",      160'(bus.dram_byte_enable), 160'(0));
        checkOutput("mr_ack",     160'(Mem_Cmd_Ack), 160'(0));
        checkOutput("mr_rdvalid", 160'(Mem_Rd_Valid), 160'(0));
        checkOutput("mr_error",   160'(arb_error), 160'(0));
        checkOutput("mr_dram_reset", 160'(bus.dram_reset), 160'(1));
        Mem_Rst = 1'b0;
        tick();
        settle();
        checkOutput("mr_dram_reset_low", 160'(bus.dram_reset), 160'(0));
        checkOutput("mr_error_clear", 160'(arb_error), 160'(0));
        bus.dram_data_valid = 1'b1;
        tick();
        bus.dram_data_valid = 1'b0;
        settle();
        checkOutput("mr_stale_return_flagged", 160'(arb_error), 160'(1));

        // Random traffic against the reference model
        doReset();
        m_en   = 1'b0;
        m_rnw  = 1'b1;
        m_addr = '0;
        m_data = '0;
        m_be   = '0;
        m_err  = 1'b0;
        m_next = 0;
        tagq.delete();
        retq.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < NP; p++)
                applyStimulus(p, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                              AW'($urandom), TW'($urandom), rand_data(), BW'($urandom));
            bus.dram_ready      = ($urandom_range(0, 3) != 0);
            bus.dram_data_valid = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.dram_data_i     = rand_data();
            Mem_Rd_Ack          = NP'($urandom);
            settle();

            checkOutput("rnd_cmd_en", 160'(bus.dram_cmd_en), 160'(m_en));
            if (m_en) begin
                checkOutput("rnd_addr", 160'(bus.dram_address), 160'(m_addr));
                checkOutput("rnd_rnw",  160'(bus.dram_rnw), 160'(m_rnw));
                checkOutput("rnd_data", 160'(bus.dram_data_o), 160'(m_data));
                checkOutput("rnd_be",   160'(bus.dram_byte_enable), 160'(m_be));
            end
            checkOutput("rnd_error", 160'(arb_error), 160'(m_err));

            m_free   = !m_en || bus.dram_ready;
            m_credit = (tagq.size() + retq.size()) < RD;
            m_g      = -1;
            if (m_free)
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (m_next + k) % NP;
                    if (m_g < 0 && Mem_Cmd_Valid[p] && (!Mem_Cmd_RNW[p] || m_credit))
                        m_g = p;
                end
            exp_ack = '0;
            if (m_g >= 0) exp_ack[m_g] = 1'b1;
            checkOutput("rnd_ack", 160'(Mem_Cmd_Ack), 160'(exp_ack));

            exp_rdv = '0;
            m_pop   = 1'b0;
            if (retq.size() > 0) begin
                exp_rdv[retq[0].port] = 1'b1;
                checkOutput("rnd_rd_tag",  160'(Mem_Rd_Tag), 160'(retq[0].tag));
                checkOutput("rnd_rd_data", 160'(Mem_Rd_Dout), 160'(retq[0].data));
                m_pop = Mem_Rd_Ack[retq[0].port];
            end
            checkOutput("rnd_rd_valid", 160'(Mem_Rd_Valid), 160'(exp_rdv));

            if (bus.dram_data_valid) begin
                if (tagq.size() == 0) m_err = 1'b1;
                else begin
                    tq_head = tagq.pop_front();
                    if (retq.size() >= RD) m_err = 1'b1;
                    else retq.push_back('{tq_head.port, tq_head.tag, bus.dram_data_i});
                end
            end
            if (m_pop) void'(retq.pop_front());
            if (m_g >= 0) begin
                m_en   = 1'b1;
                m_rnw  = Mem_Cmd_RNW[m_g];
                m_addr = Mem_Cmd_Address[m_g*AW +: AW];
                m_data = Mem_Wr_Din[m_g*DW +: DW];
                m_be   = Mem_Wr_BE[m_g*BW +: BW];
                m_next = (m_g + 1) % NP;
                if (Mem_Cmd_RNW[m_g]) tagq.push_back('{m_g, Mem_Cmd_Tag[m_g*TW +: TW]});
            end else if (m_en && bus.dram_ready) begin
                m_en = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
